// File: rtl/cu_pkg.sv
// ============================================================================
// cu_pkg : shared types and constants for the LEGv8 multicycle sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package cu_pkg;

    localparam int CW_MIN = 37;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EX_DP   = 4'd2,
        ST_EX_ADDR = 4'd3,
        ST_MEM     = 4'd4,
        ST_WB      = 4'd5,
        ST_BRANCH  = 4'd6,
        ST_TRAP    = 4'd14,
        ST_FAULT   = 4'd15
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILL, CLS_R, CLS_I, CLS_LDUR, CLS_STUR,
        CLS_B, CLS_CBZ, CLS_CBNZ, CLS_BCOND
    } cls_e;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam logic [4:0] FS_S   = 5'b10000;

    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ANDS  = 11'b11101010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
    localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OP_ANDIS = 10'b1111001000;
    localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OP_EORI  = 10'b1101001000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;

    // Field order is MSB first; total width equals CW_MIN.
    typedef struct packed {
        logic [3:0] rsvd;
        logic [3:0] cond;
        logic       addr_sel;
        logic       status_we;
        logic       pc_sel;
        logic       pc_inc;
        logic       k_sel;
        logic       mem_to_reg;
        logic       mem_rd;
        logic       mem_we;
        logic       rf_we;
        logic [4:0] sb;
        logic [4:0] sa;
        logic [4:0] da;
        logic [4:0] fs;
    } cw_t;

    // Odd condition codes invert their even partner; 4'hF behaves as always.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        r = 1'b1;
        case (cond[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c & ~z;
            3'd5:    r = (n == v);
            3'd6:    r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (cond[0] && (cond != 4'hF)) r = ~r;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cu_decode.sv
// ============================================================================
// cu_decode : combinational IR classifier, ALU function, immediate and branch outcome
// Revision: 1.0
// ============================================================================
`default_nettype none

module cu_decode
    import cu_pkg::*;
#(
    parameter int K_W = 64
) (
    input  logic [31:0]    ir_i,
    input  logic [3:0]     status_i,
    output cls_e           cls_o,
    output logic [4:0]     fs_o,
    output logic [K_W-1:0] k_o,
    output logic           taken_o
);

    always_comb begin
        cls_o   = CLS_ILL;
        fs_o    = FS_ADD;
        k_o     = '0;
        taken_o = 1'b0;
        if (ir_i[31:26] == OP_B) begin
            cls_o   = CLS_B;
            k_o     = {{(K_W-26){ir_i[25]}}, ir_i[25:0]};
            taken_o = 1'b1;
        end else if (ir_i[31:24] == OP_CBZ) begin
            cls_o   = CLS_CBZ;
            k_o     = {{(K_W-19){ir_i[23]}}, ir_i[23:5]};
            taken_o = status_i[2];
        end else if (ir_i[31:24] == OP_CBNZ) begin
            cls_o   = CLS_CBNZ;
            k_o     = {{(K_W-19){ir_i[23]}}, ir_i[23:5]};
            taken_o = ~status_i[2];
        end else if (ir_i[31:24] == OP_BCOND) begin
            cls_o   = CLS_BCOND;
            k_o     = {{(K_W-19){ir_i[23]}}, ir_i[23:5]};
            taken_o = cond_eval(ir_i[3:0], status_i);
        end else if (ir_i[31:21] == OP_LDUR || ir_i[31:21] == OP_STUR) begin
            cls_o = (ir_i[22]) ? CLS_LDUR : CLS_STUR;
            k_o   = {{(K_W-9){ir_i[20]}}, ir_i[20:12]};
        end else begin
            cls_o = CLS_R;
            case (ir_i[31:21])
                OP_ADD:  fs_o = FS_ADD;
                OP_ADDS: fs_o = FS_ADD | FS_S;
                OP_SUB:  fs_o = FS_SUB;
                OP_SUBS: fs_o = FS_SUB | FS_S;
                OP_AND:  fs_o = FS_AND;
                OP_ANDS: fs_o = FS_AND | FS_S;
                OP_ORR:  fs_o = FS_ORR;
                OP_EOR:  fs_o = FS_EOR;
                default: begin
                    // Not register-form: try the 10-bit immediate-form opcodes.
                    cls_o = CLS_I;
                    k_o   = {{(K_W-12){1'b0}}, ir_i[21:10]};
                    case (ir_i[31:22])
                        OP_ADDI:  fs_o = FS_ADD;
                        OP_ADDIS: fs_o = FS_ADD | FS_S;
                        OP_SUBI:  fs_o = FS_SUB;
                        OP_SUBIS: fs_o = FS_SUB | FS_S;
                        OP_ANDI:  fs_o = FS_AND;
                        OP_ANDIS: fs_o = FS_AND | FS_S;
                        OP_ORRI:  fs_o = FS_ORR;
                        OP_EORI:  fs_o = FS_EOR;
                        default: begin
                            cls_o = CLS_ILL;
                            k_o   = '0;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cu_sequencer.sv
// ============================================================================
// cu_sequencer : multicycle LEGv8 control sequencer with memory wait/timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module cu_sequencer
    import cu_pkg::*;
#(
    parameter int CW_W   = 37,
    parameter int K_W    = 64,
    parameter int MEM_TO = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     IR,
    input  logic [3:0]      status,
    input  logic            mem_ready,
    output logic [CW_W-1:0] control_word,
    output logic [K_W-1:0]  k,
    output logic            mem_req,
    output logic            ir_load,
    output logic [3:0]      state,
    output logic            illegal,
    output logic            fault
);

    state_e         state_q, state_d;
    logic [7:0]     wait_q, wait_d;
    logic           illegal_q, illegal_d;
    logic           fault_q, fault_d;
    cls_e           w_cls;
    logic [4:0]     w_fs;
    logic [K_W-1:0] w_k;
    logic           w_taken;
    logic           w_k_en;
    logic           w_timeout;
    cw_t            w_cw;

    cu_decode #(.K_W(K_W)) u_decode (
        .ir_i     (IR),
        .status_i (status),
        .cls_o    (w_cls),
        .fs_o     (w_fs),
        .k_o      (w_k),
        .taken_o  (w_taken)
    );

    assign w_timeout = (wait_q == 8'(MEM_TO - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        w_cw      = '0;
        w_k_en    = 1'b0;
        mem_req   = 1'b0;
        ir_load   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req     = 1'b1;
                w_cw.mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load     = 1'b1;
                    w_cw.pc_inc = 1'b1;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_cls)
                    CLS_R, CLS_I:                        state_d = ST_EX_DP;
                    CLS_LDUR, CLS_STUR:                  state_d = ST_EX_ADDR;
                    CLS_B, CLS_CBZ, CLS_CBNZ, CLS_BCOND: state_d = ST_BRANCH;
                    default: begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_EX_DP: begin
                w_k_en         = 1'b1;
                w_cw.fs        = w_fs;
                w_cw.status_we = w_fs[4];
                w_cw.rf_we     = 1'b1;
                w_cw.da        = IR[4:0];
                w_cw.sa        = IR[9:5];
                if (w_cls == CLS_R) w_cw.sb = IR[20:16];
                else                w_cw.k_sel = 1'b1;
                state_d = ST_FETCH;
            end
            ST_EX_ADDR, ST_MEM: begin
                w_k_en     = 1'b1;
                w_cw.fs    = FS_ADD;
                w_cw.sa    = IR[9:5];
                w_cw.k_sel = 1'b1;
                if (state_q == ST_EX_ADDR) begin
                    state_d = ST_MEM;
                end else begin
                    mem_req       = 1'b1;
                    w_cw.addr_sel = 1'b1;
                    if (w_cls == CLS_STUR) begin
                        w_cw.mem_we = 1'b1;
                        w_cw.sb     = IR[4:0];
                    end else begin
                        w_cw.mem_rd = 1'b1;
                    end
                    if (mem_ready) state_d = (w_cls == CLS_STUR) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                w_k_en          = 1'b1;
                w_cw.rf_we      = 1'b1;
                w_cw.da         = IR[4:0];
                w_cw.mem_to_reg = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_BRANCH: begin
                w_k_en      = 1'b1;
                w_cw.pc_sel = w_taken;
                // CBZ/CBNZ route Rt through the ALU so the datapath Z reflects it.
                if (w_cls == CLS_CBZ || w_cls == CLS_CBNZ) begin
                    w_cw.fs = FS_ORR;
                    w_cw.sa = 5'd31;
                    w_cw.sb = IR[4:0];
                end else if (w_cls == CLS_BCOND) begin
                    w_cw.cond = IR[3:0];
                end
                state_d = ST_FETCH;
            end
            ST_TRAP, ST_FAULT: ;
            default: state_d = ST_FETCH;
        endcase

        // Ready on the limit cycle wins over the timeout.
        if (mem_req && !mem_ready) begin
            if (w_timeout) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end

        // Suppress every strobe while reset is asserted so no write escapes mid-instruction.
        if (reset) begin
            w_cw    = '0;
            w_k_en  = 1'b0;
            mem_req = 1'b0;
            ir_load = 1'b0;
        end
    end

    generate
        if (CW_W > CW_MIN) begin : g_cw_pad
            assign control_word = {{(CW_W-CW_MIN){1'b0}}, w_cw};
        end else begin : g_cw_exact
            assign control_word = w_cw;
        end
    endgenerate

    assign k       = w_k_en ? w_k : '0;
    assign state   = state_q;
    assign illegal = illegal_q;
    assign fault   = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_cu_sequencer.sv
// ============================================================================
// tb_cu_sequencer : directed self-checking bench for cu_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cu_sequencer;
    import cu_pkg::*;

    localparam int CW_W = 40;
    localparam int K_W  = 64;

    logic            clock;
    logic            reset;
    logic [31:0]     IR;
    logic [3:0]      status;
    logic            mem_ready;
    logic [CW_W-1:0] control_word;
    logic [K_W-1:0]  k;
    logic            mem_req;
    logic            ir_load;
    logic [3:0]      state;
    logic            illegal;
    logic            fault;
    cw_t             cw_v;

    int n_checks = 0;
    int n_errors = 0;

    cu_sequencer #(.CW_W(CW_W), .K_W(K_W), .MEM_TO(15)) dut (
        .clock        (clock),
        .reset        (reset),
        .IR           (IR),
        .status       (status),
        .mem_ready    (mem_ready),
        .control_word (control_word),
        .k            (k),
        .mem_req      (mem_req),
        .ir_load      (ir_load),
        .state        (state),
        .illegal      (illegal),
        .fault        (fault)
    );

    assign cw_v = control_word[CW_MIN-1:0];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Branch vectors: IR, NZCV, expected pc_sel, expected k
    logic [31:0] br_ir [12] = '{32'h54000080, 32'h54000080, 32'h54000081, 32'h5400008C,
                                32'h5400008D, 32'h5400008B, 32'h54000088, 32'h54000088,
                                32'h17FFFFFE, 32'hB4000105, 32'hB5000105, 32'h54FFFFEE};
    logic [3:0]  br_st [12] = '{4'b0100, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 4'b1000,
                                4'b0010, 4'b0110, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    logic        br_tk [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] br_k  [12] = '{64'd4, 64'd4, 64'd4, 64'd4, 64'd4, 64'd4, 64'd4, 64'd4,
                                64'hFFFF_FFFF_FFFF_FFFE, 64'd8, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Runs one ALU instruction from FETCH back to FETCH with zero wait states.
    task automatic run_dp(input string tag, input logic [31:0] ir, input logic [4:0] fs,
                          input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
                          input logic ksel, input logic [63:0] kval);
        IR = ir;
        mem_ready = 1'b1;
        #1;
        check({tag, "_fetch_state"}, 64'(state), 64'(ST_FETCH));
        check({tag, "_ir_load"}, 64'(ir_load), 64'd1);
        check({tag, "_pc_inc"}, 64'(cw_v.pc_inc), 64'd1);
        tick();
        check({tag, "_decode_state"}, 64'(state), 64'(ST_DECODE));
        check({tag, "_decode_cw"}, 64'(control_word), 64'd0);
        tick();
        check({tag, "_ex_state"}, 64'(state), 64'(ST_EX_DP));
        check({tag, "_fs"}, 64'(cw_v.fs), 64'(fs));
        check({tag, "_da"}, 64'(cw_v.da), 64'(da));
        check({tag, "_sa"}, 64'(cw_v.sa), 64'(sa));
        check({tag, "_sb"}, 64'(cw_v.sb), 64'(sb));
        check({tag, "_rf_we"}, 64'(cw_v.rf_we), 64'd1);
        check({tag, "_status_we"}, 64'(cw_v.status_we), 64'(fs[4]));
        check({tag, "_k_sel"}, 64'(cw_v.k_sel), 64'(ksel));
        check({tag, "_k"}, k, kval);
        check({tag, "_cw_pad"}, 64'(control_word[CW_W-1:CW_MIN]), 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        IR = 32'd0;
        status = 4'd0;
        mem_ready = 1'b1;
        tick();
        tick();
        check("rst_state", 64'(state), 64'(ST_FETCH));
        check("rst_cw", 64'(control_word), 64'd0);
        check("rst_k", k, 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_ir_load", 64'(ir_load), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        reset = 1'b0;
        #1;

        run_dp("add",  32'h8B010002, 5'b01000, 5'd2, 5'd0, 5'd1, 1'b0, 64'd0);
        run_dp("addi", 32'h913FFC41, 5'b01000, 5'd1, 5'd2, 5'd0, 1'b1, 64'hFFF);
        run_dp("subs", 32'hEB050083, 5'b11001, 5'd3, 5'd4, 5'd5, 1'b0, 64'd0);

        // LDUR X3,[X4,#8] with three memory wait states
        IR = 32'hF8408083;
        mem_ready = 1'b1;
        tick();
        tick();
        check("ld_ex_state", 64'(state), 64'(ST_EX_ADDR));
        check("ld_ex_k", k, 64'd8);
        check("ld_ex_sa", 64'(cw_v.sa), 64'd4);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_state", 64'(state), 64'(ST_MEM));
            check("ld_wait_req", 64'(mem_req), 64'd1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("ld_mem_state", 64'(state), 64'(ST_MEM));
        check("ld_mem_rd", 64'(cw_v.mem_rd), 64'd1);
        check("ld_mem_we", 64'(cw_v.mem_we), 64'd0);
        tick();
        check("ld_wb_state", 64'(state), 64'(ST_WB));
        check("ld_wb_da", 64'(cw_v.da), 64'd3);
        check("ld_wb_k", k, 64'd8);
        check("ld_wb_rf_we", 64'(cw_v.rf_we), 64'd1);
        check("ld_wb_m2r", 64'(cw_v.mem_to_reg), 64'd1);
        tick();
        check("ld_done_state", 64'(state), 64'(ST_FETCH));

        // STUR X6,[X7,#-8], zero wait states
        IR = 32'hF81F80E6;
        tick();
        tick();
        check("st_ex_k", k, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        check("st_mem_state", 64'(state), 64'(ST_MEM));
        check("st_mem_we", 64'(cw_v.mem_we), 64'd1);
        check("st_mem_sb", 64'(cw_v.sb), 64'd6);
        check("st_addr_sel", 64'(cw_v.addr_sel), 64'd1);
        tick();
        check("st_done_state", 64'(state), 64'(ST_FETCH));

        for (int i = 0; i < 12; i++) begin
            IR = br_ir[i];
            status = br_st[i];
            tick();
            tick();
            check("br_state", 64'(state), 64'(ST_BRANCH));
            check("br_pc_sel", 64'(cw_v.pc_sel), 64'(br_tk[i]));
            check("br_k", k, br_k[i]);
            check("br_rf_we", 64'(cw_v.rf_we), 64'd0);
            tick();
        end
        status = 4'd0;

        // Ready arrives on the 15th wait cycle: no fault
        IR = 32'h8B010002;
        mem_ready = 1'b0;
        #1;
        repeat (14) tick();
        check("to_edge_state", 64'(state), 64'(ST_FETCH));
        mem_ready = 1'b1;
        tick();
        check("to_edge_decode", 64'(state), 64'(ST_DECODE));
        check("to_edge_fault", 64'(fault), 64'd0);
        tick();
        tick();

        // Ready never arrives: fault after 15 wait cycles
        mem_ready = 1'b0;
        #1;
        repeat (14) tick();
        check("to_pre_state", 64'(state), 64'(ST_FETCH));
        check("to_pre_fault", 64'(fault), 64'd0);
        tick();
        check("to_state", 64'(state), 64'(ST_FAULT));
        check("to_fault", 64'(fault), 64'd1);
        check("to_mem_req", 64'(mem_req), 64'd0);
        check("to_cw", 64'(control_word), 64'd0);
        mem_ready = 1'b1;
        tick();
        tick();
        check("to_hold_state", 64'(state), 64'(ST_FAULT));
        check("to_hold_fault", 64'(fault), 64'd1);
        pulse_reset();
        check("to_rst_state", 64'(state), 64'(ST_FETCH));
        check("to_rst_fault", 64'(fault), 64'd0);

        // Undefined opcode
        IR = 32'd0;
        tick();
        tick();
        check("ill_state", 64'(state), 64'(ST_TRAP));
        check("ill_flag", 64'(illegal), 64'd1);
        check("ill_mem_req", 64'(mem_req), 64'd0);
        check("ill_cw", 64'(control_word), 64'd0);
        tick();
        tick();
        check("ill_hold_state", 64'(state), 64'(ST_TRAP));
        check("ill_hold_flag", 64'(illegal), 64'd1);
        pulse_reset();
        check("ill_rst_state", 64'(state), 64'(ST_FETCH));
        check("ill_rst_flag", 64'(illegal), 64'd0);

        // Reset during a STUR memory wait
        IR = 32'hF81F80E6;
        mem_ready = 1'b1;
        #1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("strst_mem_state", 64'(state), 64'(ST_MEM));
        check("strst_mem_we", 64'(cw_v.mem_we), 64'd1);
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("strst_we_blocked", 64'(cw_v.mem_we), 64'd0);
        check("strst_req_blocked", 64'(mem_req), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("strst_state", 64'(state), 64'(ST_FETCH));
        check("strst_fetch_req", 64'(mem_req), 64'd1);
        check("strst_fetch_we", 64'(cw_v.mem_we), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
